// File: rtl/stream_merge2.sv
// Purpose: round-robin merge of streams A and B into a 2-entry queue tagged with source (sel).
// Latency: a word accepted into an empty queue is presented on out_* the following cycle.
// Backpressure: readies come from a registered space flag, never combinationally from out_ready.
module stream_merge2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       count
);

    typedef struct packed {
        logic             src;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     ent_d [2];
    logic [1:0] count_q, count_d;
    logic       space_q, space_d;
    logic       last_q, last_d;   // 0 = A, 1 = B

    logic   grant_a, grant_b;
    logic   a_fire, b_fire;
    logic   push, pop;
    entry_t new_ent;

    // Arbitration: a lone valid wins, a tie goes to the source not served last.
    always_comb begin
        grant_a   = a_valid && (!b_valid || last_q);
        grant_b   = b_valid && (!a_valid || !last_q);
        a_ready   = space_q && grant_a;
        b_ready   = space_q && grant_b;
        a_fire    = a_valid && a_ready;
        b_fire    = b_valid && b_ready;
        push      = a_fire || b_fire;
        new_ent.src  = b_fire;
        new_ent.data = b_fire ? b_data : a_data;
        out_valid = (count_q != 2'd0);
        pop       = out_valid && out_ready;
        out_data  = out_valid ? ent_q[0].data : '0;
        sel       = out_valid ? ent_q[0].src : 1'b0;
        count     = count_q;
    end

    // Queue next state: head lives in entry 0, pops shift entry 1 forward.
    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        last_d  = last_q;
        if (push) begin
            last_d = b_fire;
        end
        case ({push, pop})
            2'b10: begin
                ent_d[count_q[0]] = new_ent;
                count_d           = count_q + 2'd1;
            end
            2'b01: begin
                ent_d[0] = ent_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is 1 here (no push when full), so the new word becomes head.
                ent_d[0] = new_ent;
            end
            default: begin
            end
        endcase
        space_d = (count_d != 2'd2);
    end

    // State registers with synchronous reset; buffered words are discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= 2'd0;
            space_q <= 1'b1;
            last_q  <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            space_q <= space_d;
            last_q  <= last_d;
        end
    end

endmodule
